// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared constants and types for the nibble-serial adder controller and its adder slice.
package nibble_serial_adder_ctrl_pkg;

  localparam int NIBBLE_W    = 4;
  localparam int MAX_NIBBLES = 8;
  localparam int CNT_W       = $clog2(MAX_NIBBLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for the nibble-serial adder; master drives operands and accepts results.
interface nibble_serial_adder_ctrl_if #(
  parameter int NIBBLES = 4
) ();
  import nibble_serial_adder_ctrl_pkg::*;

  localparam int W = NIBBLE_W * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/nibble_serial_adder_ctrl_nibble_adder.sv
// Combinational 4-bit ripple-carry slice built from a chain of full-adder cells.
module nibble_adder
  import nibble_serial_adder_ctrl_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a4,
  input  logic [NIBBLE_W-1:0] b4,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s4,
  output logic                co
);

  logic [NIBBLE_W:0] carry;

  assign carry[0] = ci;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s4[i]      = a4[i] ^ b4[i] ^ carry[i];
    assign carry[i+1] = (a4[i] & b4[i]) | (carry[i] & (a4[i] ^ b4[i]));
  end

  assign co = carry[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-nibble adder that reuses one 4-bit slice, LSB nibble first, with the carry registered between nibbles.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input logic                      clk,
  input logic                      rst,
  nibble_serial_adder_ctrl_if.slave bus
);

  localparam int W = NIBBLE_W * NIBBLES;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_co;
  logic [W-1:0]        slice_ext;
  logic [W-1:0]        acc_shift;
  logic                last_nibble;

  nibble_adder u_slice (
    .a4 (a_q[NIBBLE_W-1:0]),
    .b4 (b_q[NIBBLE_W-1:0]),
    .ci (carry_q),
    .s4 (slice_s),
    .co (slice_co)
  );

  // Partial sums build up in acc_q so the visible sum only changes when an operation completes.
  always_comb begin
    slice_ext                     = '0;
    slice_ext[W-1 -: NIBBLE_W]    = slice_s;
    acc_shift                     = (acc_q >> NIBBLE_W) | slice_ext;
    last_nibble                   = (cnt_q == CNT_W'(NIBBLES - 1));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    carry_d     = carry_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d        = bus.a;
          b_d        = bus.b;
          carry_d    = bus.cin;
          cnt_d      = '0;
          acc_d      = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        acc_d   = acc_shift;
        a_d     = a_q >> NIBBLE_W;
        b_d     = b_q >> NIBBLE_W;
        carry_d = slice_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_nibble) begin
          state_d     = DONE;
          sum_d       = acc_shift;
          cout_d      = slice_co;
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
          cnt_d       = '0;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for the nibble-serial adder: a 4-nibble and a 1-nibble instance sharing clock and reset.
module tb_nibble_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl_if #(.NIBBLES(4)) bus4 ();
  nibble_serial_adder_ctrl_if #(.NIBBLES(1)) bus1 ();

  nibble_serial_adder_ctrl #(.NIBBLES(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one operation on the 4-nibble instance, then waits (bounded) for out_valid.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic c,
                               input bit garbage, output int lat, output int busy_cnt);
    bus4.a        = a;
    bus4.b        = b;
    bus4.cin      = c;
    bus4.in_valid = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (bus4.out_valid !== 1'b1 && lat < 20) begin
      if (bus4.busy === 1'b1) busy_cnt++;
      if (garbage) begin
        bus4.in_valid = lat[0];
        bus4.a        = 16'($urandom);
        bus4.b        = 16'($urandom);
        bus4.cin      = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    if (garbage) begin
      bus4.in_valid = 1'b1;
      @(negedge clk);
      bus4.in_valid = 1'b0;
    end
  endtask

  task automatic releaseResult4(input string tag);
    bus4.out_ready = 1'b1;
    @(negedge clk);
    bus4.out_ready = 1'b0;
    checkOutput({tag, "_in_ready_after"}, 32'(bus4.in_ready), 32'd1);
    checkOutput({tag, "_out_valid_after"}, 32'(bus4.out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int busy_cnt;

    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_in_ready", 32'(bus4.in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus4.busy), 32'd0);
    checkOutput("rst_sum", 32'(bus4.sum), 32'h0);
    checkOutput("rst_cout", 32'(bus4.cout), 32'd0);
    checkOutput("rst1_in_ready", 32'(bus1.in_ready), 32'd1);

    // Case 1: basic add, latency and busy length
    applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0, lat, busy_cnt);
    checkOutput("c1_latency", 32'(lat), 32'd4);
    checkOutput("c1_busy_cycles", 32'(busy_cnt), 32'd4);
    checkOutput("c1_sum", 32'(bus4.sum), 32'h2345);
    checkOutput("c1_cout", 32'(bus4.cout), 32'd0);
    checkOutput("c1_in_ready_done", 32'(bus4.in_ready), 32'd0);
    releaseResult4("c1");
    checkOutput("c1_sum_held_idle", 32'(bus4.sum), 32'h2345);

    // Case 2: carry rippling through every registered nibble boundary
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, busy_cnt);
    checkOutput("c2a_sum", 32'(bus4.sum), 32'h0000);
    checkOutput("c2a_cout", 32'(bus4.cout), 32'd1);
    releaseResult4("c2a");
    applyStimulus(16'h0000, 16'hFFFF, 1'b1, 1'b0, lat, busy_cnt);
    checkOutput("c2b_sum", 32'(bus4.sum), 32'h0000);
    checkOutput("c2b_cout", 32'(bus4.cout), 32'd1);
    releaseResult4("c2b");

    // Case 3: backpressure holds result stable
    applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0, lat, busy_cnt);
    for (int i = 0; i < 6; i++) begin
      checkOutput("c3_hold", {12'h0, bus4.out_valid, bus4.in_ready, bus4.cout, bus4.busy, bus4.sum},
                  {12'h0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000});
      @(negedge clk);
    end
    releaseResult4("c3");
    applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 1'b0, lat, busy_cnt);
    checkOutput("c3_second_sum", 32'(bus4.sum), 32'h1000);
    checkOutput("c3_second_cout", 32'(bus4.cout), 32'd0);
    releaseResult4("c3b");

    // Case 4: in_valid toggling with garbage while busy or done
    applyStimulus(16'h4321, 16'h1234, 1'b1, 1'b1, lat, busy_cnt);
    checkOutput("c4_latency", 32'(lat), 32'd4);
    checkOutput("c4_sum", 32'(bus4.sum), 32'h5556);
    checkOutput("c4_cout", 32'(bus4.cout), 32'd0);
    releaseResult4("c4");
    @(negedge clk);
    checkOutput("c4_no_extra_op", {30'h0, bus4.busy, bus4.in_ready}, {30'h0, 1'b0, 1'b1});

    // Case 5: reset in the second RUN cycle discards the operation
    bus4.a = 16'h1234; bus4.b = 16'h4321; bus4.cin = 1'b0; bus4.in_valid = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("c5_in_ready", 32'(bus4.in_ready), 32'd1);
    checkOutput("c5_out_valid", 32'(bus4.out_valid), 32'd0);
    checkOutput("c5_busy", 32'(bus4.busy), 32'd0);
    checkOutput("c5_sum", 32'(bus4.sum), 32'h0);
    checkOutput("c5_cout", 32'(bus4.cout), 32'd0);
    applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0, lat, busy_cnt);
    checkOutput("c5_next_sum", 32'(bus4.sum), 32'h0100);
    checkOutput("c5_next_cout", 32'(bus4.cout), 32'd0);
    releaseResult4("c5");

    // Reset together with in_valid must not capture operands
    bus4.a = 16'hFFFF; bus4.b = 16'hFFFF; bus4.in_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    bus4.in_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_vs_valid", {30'h0, bus4.busy, bus4.in_ready}, {30'h0, 1'b0, 1'b1});

    // Case 6: single-nibble instance
    bus1.a = 4'h9; bus1.b = 4'h8; bus1.cin = 1'b1; bus1.in_valid = 1'b1;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    checkOutput("c6_busy", 32'(bus1.busy), 32'd1);
    lat = 0;
    while (bus1.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("c6_latency", 32'(lat), 32'd1);
    checkOutput("c6_sum", 32'(bus1.sum), 32'h2);
    checkOutput("c6_cout", 32'(bus1.cout), 32'd1);
    bus1.out_ready = 1'b1;
    @(negedge clk);
    bus1.out_ready = 1'b0;
    checkOutput("c6_in_ready_after", 32'(bus1.in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
